instr_encoder: RTL and testbench

Packs decoded RISC-V instruction fields (opcode, funct3, funct7, rs1, rs2, rd, immediate) back into 32-bit instruction words for the six base formats R, I, S, B, U and J. It buffers the packed words in a small FIFO and streams them into an instruction-memory write port at consecutive word addresses. It is the encode side of the core's field decoder and is used by the program loader and by test harnesses to build instruction memory images in-system.

---
 rtl/instr_encoder_if.sv | 44 ++++
 rtl/instr_encoder.sv | 136 +++++++++++++
 tb/tb_instr_encoder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder_if
//  Brief    : Field-tuple input handshake and instruction-memory write port.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              fmt;
    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic [`INSTR_SIZE-1:0]  imm;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [`INSTR_SIZE-1:0]  mem_wdata;
    logic                    mem_ready;

    // Source of field tuples and sink of memory writes
    modport master (
        output in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    // The encoder itself
    modport slave (
        input  in_valid, fmt, opcode, funct3, funct7, rs1, rs2, rd, imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Brief    : Packs RISC-V fields into 32-bit words, buffers and streams them
//             to instruction memory at consecutive word addresses.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif

module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int BASE_ADDR  = 0
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic       clear,
    instr_encoder_if.slave  bus,
    output logic            busy,
    output logic            fmt_err,
    output logic            wrapped
);

    localparam int                    c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_ptr_w:0]      c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_base  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_step  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_top   = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    localparam logic [2:0] c_FMT_R = 3'd0;
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;

    logic [`INSTR_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_ptr_w:0]       r_count;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_fmt_err;
    logic                   r_wrapped;

    logic [`INSTR_SIZE-1:0] w_word;
    logic                   w_fmt_ok;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_bad;
    logic                   w_pop;

    // Field packing; bit 31 first in every concatenation
    always_comb begin
        w_word   = '0;
        w_fmt_ok = 1'b1;
        case (bus.fmt)
            c_FMT_R: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            c_FMT_I: w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            c_FMT_S: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:0], bus.opcode};
            c_FMT_B: w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:1], bus.imm[11], bus.opcode};
            c_FMT_U: w_word = {bus.imm[31:12], bus.rd, bus.opcode};
            c_FMT_J: w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                               bus.rd, bus.opcode};
            default: w_fmt_ok = 1'b0;
        endcase
    end

    assign w_full   = (r_count == c_depth);
    assign w_ready  = !w_full && !clear;
    assign w_accept = bus.in_valid && w_ready;
    assign w_push   = w_accept && w_fmt_ok;
    assign w_bad    = w_accept && !w_fmt_ok;
    assign w_pop    = busy && bus.mem_ready && !clear;

    assign busy          = (r_count != '0);
    assign fmt_err       = r_fmt_err;
    assign wrapped       = r_wrapped;
    assign bus.in_ready  = w_ready;
    assign bus.mem_we    = busy;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = busy ? r_mem[r_rptr] : '0;

    // Storage is never read while empty, so it needs no reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_addr    <= c_base;
            r_fmt_err <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (clear) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_addr    <= c_base;
            r_fmt_err <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_addr <= r_addr + c_step;
                if (r_addr == c_top) begin
                    r_wrapped <= 1'b1;
                end
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_bad) begin
                r_fmt_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Brief    : Directed self-checking bench with a write-side scoreboard.
//  Revision : 1.0  initial release
// ============================================================================

module tb_instr_encoder;

    logic clk;
    logic rstn;
    logic clear;
    logic busy;
    logic fmt_err;
    logic wrapped;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] sb [$];
    logic [31:0] mon_w;
    logic [3:0]  exp_addr    = 4'h0;
    int          cyc         = 0;
    int          last_wr_cyc = 0;
    int          prev_wr_cyc = 0;
    int          wr_count    = 0;
    int          wr_snap;

    instr_encoder_if #(.ADDR_WIDTH(4)) bus ();

    instr_encoder #(
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (4),
        .BASE_ADDR  (0)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (clear),
        .bus     (bus.slave),
        .busy    (busy),
        .fmt_err (fmt_err),
        .wrapped (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Write-side monitor: every completed write is checked against the scoreboard
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            sb.delete();
            exp_addr = 4'h0;
        end else if (clear) begin
            sb.delete();
            exp_addr = 4'h0;
        end else if (bus.mem_we === 1'b1 && bus.mem_ready) begin
            wr_count++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_write: observed addr=0x%0h data=0x%08h expected no write",
                       bus.mem_addr, bus.mem_wdata);
            end else begin
                mon_w = sb.pop_front();
                n_cmp++;
                assert (bus.mem_wdata === mon_w) else begin
                    n_fail++;
                    $error("FAIL wr_data: observed=0x%08h expected=0x%08h", bus.mem_wdata, mon_w);
                end
                n_cmp++;
                assert (bus.mem_addr === exp_addr) else begin
                    n_fail++;
                    $error("FAIL wr_addr: observed=0x%0h expected=0x%0h", bus.mem_addr, exp_addr);
                end
            end
            exp_addr = exp_addr + 4'h4;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] d, input logic [31:0] im, input logic [31:0] exp_w);
        int n;
        bus.fmt      = f;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.rd       = d;
        bus.imm      = im;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $error("FAIL send_timeout: observed in_ready=%b expected 1 within 50 cycles", bus.in_ready);
        end else begin
            @(posedge clk);
            #1;
            if (f < 3'd6) sb.push_back(exp_w);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rstn          = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.fmt       = 3'd0;
        bus.opcode    = 7'd0;
        bus.funct3    = 3'd0;
        bus.funct7    = 7'd0;
        bus.rs1       = 5'd0;
        bus.rs2       = 5'd0;
        bus.rd        = 5'd0;
        bus.imm       = 32'd0;
        bus.mem_ready = 1'b1;

        // Reset state
        #12;
        check("rst_mem_we",    32'(bus.mem_we),    32'd0);
        check("rst_mem_wdata", bus.mem_wdata,      32'd0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_flags",     32'({fmt_err, wrapped}), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // R then I, back to back
        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0,         32'h002081B3);
        send(3'd1, 7'h13, 3'd0, 7'h7F, 5'd0, 5'd9, 5'd1, 32'd5,        32'h00500093);
        drain();
        check("ri_consecutive", 32'(last_wr_cyc - prev_wr_cyc), 32'd1);
        check("ri_busy_low",    32'(busy), 32'd0);

        // S then B (negative offset)
        send(3'd2, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8,         32'h0020A423);
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC,  32'hFE208EE3);
        drain();

        // U then J
        send(3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000,  32'h123452B7);
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h00000800,  32'h001000EF);
        drain();

        // Backpressure: fill the FIFO with the memory stalled
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'(i),
                 (32'(i) << 20) | 32'h00000093);
        end
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_we",    32'(bus.mem_we),   32'd1);
        check("bp_hold_wdata", bus.mem_wdata,     32'h00100093);
        check("bp_hold_addr",  32'(bus.mem_addr), 32'h8);
        bus.mem_ready = 1'b1;
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093);
        drain();
        check("bp_busy_low", 32'(busy), 32'd0);

        // Invalid fmt is accepted, flagged and never written
        wr_snap = wr_count;
        send(3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1, 32'h0);
        check("fmt_err_set", 32'(fmt_err), 32'd1);
        send(3'd0, 7'h33, 3'd7, 7'h20, 5'd31, 5'd30, 5'd29, 32'd0, 32'h41EFFEB3);
        send(3'd1, 7'h03, 3'd2, 7'd0, 5'd2, 5'd0, 5'd10, 32'hFFFFFFFF, 32'hFFF12503);
        drain();
        check("fmt_err_writes", 32'(wr_count - wr_snap), 32'd2);
        check("fmt_err_sticky", 32'(fmt_err), 32'd1);

        // clear drops a pending word even with mem_ready high
        bus.mem_ready = 1'b0;
        send(3'd4, 7'h17, 3'd0, 7'd0, 5'd0, 5'd0, 5'd7, 32'hABCDE000, 32'hABCDE397);
        wr_snap       = wr_count;
        bus.mem_ready = 1'b1;
        clear         = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clr_addr",    32'(bus.mem_addr), 32'd0);
        check("clr_fmt_err", 32'(fmt_err),      32'd0);
        check("clr_wrapped", 32'(wrapped),      32'd0);
        check("clr_busy",    32'(busy),         32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("clr_no_write", 32'(wr_count - wr_snap), 32'd0);

        // Address wrap across the 16-byte space
        for (int i = 0; i < 5; i++) begin
            send(3'd0, 7'h33, 3'd0, 7'd0, 5'(i), 5'd0, 5'(i + 1), 32'd0,
                 (32'(i) << 15) | (32'(i + 1) << 7) | 32'h33);
        end
        drain();
        check("wrap_flag", 32'(wrapped),      32'd1);
        check("wrap_addr", 32'(bus.mem_addr), 32'h4);

        // Asynchronous reset mid-stream, away from any clock edge
        bus.mem_ready = 1'b0;
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd7, 32'h00700093);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 32'h00800093);
        send(3'd6, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd8, 32'h0);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst_mem_we",    32'(bus.mem_we),   32'd0);
        check("arst_mem_wdata", bus.mem_wdata,     32'd0);
        check("arst_mem_addr",  32'(bus.mem_addr), 32'd0);
        check("arst_busy",      32'(busy),         32'd0);
        check("arst_in_ready",  32'(bus.in_ready), 32'd1);
        check("arst_flags",     32'({fmt_err, wrapped}), 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        bus.mem_ready = 1'b1;
        send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 32'hFFFFF06F);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
